// File: rtl/adder_pkg.sv
// Shared constants and helpers for the adder result path.
package adder_pkg;

  localparam int unsigned WIDTH_DEF   = 16;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned CARRY_CNT_W = 16;

  // Pointer carries one extra bit so full and empty can be told apart.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/adder_result_fifo_mem.sv
// Register-array storage: synchronous write, asynchronous (show-ahead) read.
module adder_result_fifo_mem #(
  parameter int unsigned DW = 17,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned ENTRIES = 1 << AW;

  logic [DW-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/adder_result_collector.sv
// Buffers adder {carry, sum} results in a small FIFO with valid/ready readout.
// Define ADDER_RESULT_STATS_EN to add the saturating carry-out counter port.
module adder_result_collector
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  input  logic [WIDTH:0]                i_result,
  output logic                          o_ready,
  output logic                          o_valid,
  output logic [WIDTH:0]                o_data,
  input  logic                          i_ready,
  output logic [ptr_width(DEPTH)-1:0]   o_level
`ifdef ADDER_RESULT_STATS_EN
  ,
  output logic [CARRY_CNT_W-1:0]        o_carry_count
`endif
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam int unsigned DW = WIDTH + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] level;
  logic          push;
  logic          pop;

  // Handshake flags depend only on the registered level.
  assign o_ready = (level != PW'(DEPTH));
  assign o_valid = (level != '0);
  assign o_level = level;
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + PW'(1);
        2'b01:   level <= level - PW'(1);
        default: level <= level;
      endcase
    end
  end

  adder_result_fifo_mem #(
    .DW (DW),
    .AW (AW)
  ) u_mem (
    .clk   (i_clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (i_result),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (o_data)
  );

`ifdef ADDER_RESULT_STATS_EN
  logic [CARRY_CNT_W-1:0] carry_count;

  // Counts accepted words with carry-out set, holding at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      carry_count <= '0;
    end else if (push && i_result[WIDTH] && (carry_count != '1)) begin
      carry_count <= carry_count + CARRY_CNT_W'(1);
    end
  end

  assign o_carry_count = carry_count;
`endif

endmodule
